rm_iter_mul: RTL and testbench
==============================

// Module: rm_iter_mul
// PURPOSE
//  Parametrised sequential successor of the 4x4 signed 2-bit-digit multiplier.
//  Multiplies two W-bit operands by processing one 2-bit digit of b per clock.
//  Each operand is independently signed or unsigned.
//  Valid/ready handshakes on input and output; sits in datapaths where area outweighs throughput.
//  Result is exact: 2W bits, no truncation.
// PARAMETERS
//  W  8  operand width; even, >=4 (elaborate-time error otherwise); digits ND = W/2
// PORTS
//  clk       in   1     clock; all state updates on rising edge
//  rst       in   1     synchronous reset, active-high
//  in_valid  in   1     operand pair valid
//  in_ready  out  1     block can accept operands (high only in IDLE)
//  a         in   W     multiplicand
//  b         in   W     multiplier (consumed 2 bits per cycle, LSB digit first)
//  a_signed  in   1     1: a is two's complement; 0: unsigned
//  b_signed  in   1     1: b is two's complement; 0: unsigned
//  out_valid out  1     result valid; held until out_ready
//  out_ready in   1     downstream accepts result
//  out       out  2W    product a*b, two's complement if a_signed|b_signed
// BEHAVIOUR
//  Single clock; reset is synchronous and active-high (clk, rst).
//  Reset: state=IDLE, out_valid=0, out=0, accumulator/counters cleared; rst overrides all events.
//  Inputs presented while rst=1 are ignored; in_ready=1 from first cycle after rst deasserts.
//  FSM IDLE -> CALC -> DONE -> IDLE.
//  IDLE: in_ready=1.
//   On in_valid&in_ready: latch the following, then go CALC:
//    - a_ext = a sign-ext (a_signed) or zero-ext to 2W
//    - b, b_signed
//    - acc = 0, k = 0
//  CALC: in_ready=0; each edge processes digit d = b[2k+1:2k]:
//   - digits 0..ND-2: unsigned value 0..3
//   - digit ND-1: signed -2..1 if b_signed, else 0..3
//   - acc += (a_ext * d) << 2k, mod 2^(2W); then k++
//   - after digit ND-1 -> DONE. Fixed latency ND cycles from accept edge to out_valid=1.
//  DONE: out_valid=1, out=acc; out stable while out_valid&~out_ready.
//   - On out_ready -> IDLE, out_valid=0 next cycle; out keeps last value.
//  No overlap: next operand accepted no earlier than the cycle after the DONE handshake.
//   Minimum issue interval is ND+2 cycles.
//  in_valid in CALC/DONE is ignored; a/b changes after acceptance have no effect.
//  Reset mid-CALC or mid-DONE: operation is discarded, no out_valid pulse.
//  Extremes are exact: signed (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) fits in 2W bits.
//  Mixed-sign modes are exact for all inputs.
// CONFIGURATION
//  RM_ITER_EARLY_TERM_EN defined:
//   - after processing digit k, if b bits above digit k are all zero -> DONE immediately
//   - at least one digit is always processed; latency = 1 + index of highest nonzero digit (min 1)
//   - signed b with a nonzero top digit always runs full ND cycles
//  Undefined: fixed ND-cycle latency for all operands. out values identical in both builds.
// TESTING
//  W=8, a=0x80,b=0x80, a_signed=b_signed=1 -> out=0x4000, out_valid 4 cycles after accept
//  W=8, a=0xFF,b=0xFF, both unsigned -> out=0xFE01; a_signed=1 only -> out=0xFF01 (-255)
//  Hold out_ready=0 for 5 cycles in DONE -> out_valid, out stable; in_ready=0; in_valid pulses ignored
//  Assert rst on 2nd CALC cycle -> out_valid never rises; in_ready=1 after reset; next op correct
//  RM_ITER_EARLY_TERM_EN, W=8, a=0x07,b=0x01 unsigned -> out=0x0007 after 1 cycle; b=0x40 -> 4 cycles
//  W=4 exhaustive 256 pairs x 4 sign modes vs reference model, random out_ready backpressure -> all match

Source files
------------

// File: rtl/rm_iter_mul.sv
// Iterative W x W multiplier: retires one 2-bit digit of b per clock, each operand independently signed/unsigned, exact 2W-bit product.
// Latency: ND=W/2 cycles from accept to out_valid (RM_ITER_EARLY_TERM_EN: 1 + index of highest nonzero digit of b).
// Backpressure: in_ready only in IDLE; out_valid/out held until out_ready, one operation in flight at a time.
module rm_iter_mul #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           a_signed,
    input  logic           b_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out
);

    localparam int ND = W / 2;
    localparam int KW = (ND > 1) ? $clog2(ND) : 1;

    generate
        if ((W % 2) != 0 || W < 4) begin : g_bad_width
            $error("rm_iter_mul: W must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [2*W-1:0] a_sh;      // a_ext pre-shifted by 2k
    logic [W-1:0]   b_sh;      // b shifted so the current digit sits in [1:0]
    logic           b_sgn;
    logic [KW-1:0]  k;
    logic [2*W-1:0] acc, pp, acc_nxt, out_q;
    logic           top_digit, neg_top, last_digit;

    always_comb begin
        top_digit = (k == KW'(ND - 1));
        neg_top   = top_digit & b_sgn;
        pp        = '0;
        unique case (b_sh[1:0])
            2'b00: pp = '0;
            2'b01: pp = a_sh;
            2'b10: pp = neg_top ? -(a_sh << 1) : (a_sh << 1);
            2'b11: pp = neg_top ? -a_sh : (a_sh + (a_sh << 1));
            default: pp = '0;
        endcase
        acc_nxt = acc + pp;
`ifdef RM_ITER_EARLY_TERM_EN
        // Raw bits above the current digit all zero means no further contribution, whatever the sign mode.
        last_digit = top_digit || (b_sh[W-1:2] == '0);
`else
        last_digit = top_digit;
`endif
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = CALC;
            end
            CALC: begin
                if (last_digit) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            b_sgn <= 1'b0;
            k     <= '0;
            acc   <= '0;
            out_q <= '0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                a_sh  <= a_signed ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
                b_sh  <= b;
                b_sgn <= b_signed;
                k     <= '0;
                acc   <= '0;
            end else if (state_q == CALC) begin
                acc  <= acc_nxt;
                a_sh <= a_sh << 2;
                b_sh <= b_sh >> 2;
                k    <= k + KW'(1);
                if (last_digit) out_q <= acc_nxt;
            end
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_rm_iter_mul.sv
// Directed bench for rm_iter_mul: W=8 instance for latency/handshake cases, W=4 instance swept over all operand pairs and sign modes.
module tb_rm_iter_mul;

    logic        clk;
    logic        rst;

    logic        in_valid, in_ready, a_signed, b_signed, out_valid, out_ready;
    logic [7:0]  a, b;
    logic [15:0] out;

    logic        in_valid4, in_ready4, a_signed4, b_signed4, out_valid4, out_ready4;
    logic [3:0]  a4, b4;
    logic [7:0]  out4;

    int errors = 0;
    int checks = 0;

`ifdef RM_ITER_EARLY_TERM_EN
    localparam int LAT_B01 = 1;
`else
    localparam int LAT_B01 = 4;
`endif

    rm_iter_mul #(.W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    rm_iter_mul #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .a_signed(a_signed4), .b_signed(b_signed4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out(out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation on the W=8 instance; lat counts edges after the accept edge until out_valid (-1 on timeout).
    task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tsa, input logic tsb,
                          output logic [15:0] res, output int lat);
        int t;
        t = 0;
        while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
        a = ta; b = tb; a_signed = tsa; b_signed = tsb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        res = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = c; break; end
        end
        if (lat > 0) begin
            res = out;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1; a = 8'h11; b = 8'h22;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out !== 16'h0000) begin errors++; $display("FAIL reset_out got=%h exp=0000", out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ignores_in_valid got=%b exp=1", in_ready); end
    endtask

    task automatic test_signed_extremes();
        logic [15:0] r; int l;
        do_op8(8'h80, 8'h80, 1'b1, 1'b1, r, l);
        checks++; if (r !== 16'h4000) begin errors++; $display("FAIL min_x_min got=%h exp=4000", r); end
        checks++; if (l !== 4) begin errors++; $display("FAIL min_x_min_latency got=%0d exp=4", l); end
    endtask

    task automatic test_sign_modes();
        logic [15:0] r; int l;
        do_op8(8'hFF, 8'hFF, 1'b0, 1'b0, r, l);
        checks++; if (r !== 16'hFE01) begin errors++; $display("FAIL ff_uu got=%h exp=fe01", r); end
        do_op8(8'hFF, 8'hFF, 1'b1, 1'b0, r, l);
        checks++; if (r !== 16'hFF01) begin errors++; $display("FAIL ff_su got=%h exp=ff01", r); end
        do_op8(8'hFF, 8'hFF, 1'b0, 1'b1, r, l);
        checks++; if (r !== 16'hFF01) begin errors++; $display("FAIL ff_us got=%h exp=ff01", r); end
        do_op8(8'hFF, 8'hFF, 1'b1, 1'b1, r, l);
        checks++; if (r !== 16'h0001) begin errors++; $display("FAIL ff_ss got=%h exp=0001", r); end
        do_op8(8'h80, 8'hFF, 1'b1, 1'b0, r, l);
        checks++; if (r !== 16'h8080) begin errors++; $display("FAIL min_x_255 got=%h exp=8080", r); end
    endtask

    task automatic test_backpressure();
        int  t;
        logic bad_vld, bad_dat, bad_rdy;
        a = 8'h12; b = 8'h34; a_signed = 1'b0; b_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
        bad_vld = 1'b0; bad_dat = 1'b0; bad_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0]; a = 8'hAA; b = 8'h55;
            @(posedge clk); #1;
            if (out_valid !== 1'b1) bad_vld = 1'b1;
            if (out !== 16'h03A8) bad_dat = 1'b1;
            if (in_ready !== 1'b0) bad_rdy = 1'b1;
        end
        in_valid = 1'b0;
        checks++; if (bad_vld) begin errors++; $display("FAIL bp_out_valid_held got=dropped exp=held"); end
        checks++; if (bad_dat) begin errors++; $display("FAIL bp_out_stable got=%h exp=03a8", out); end
        checks++; if (bad_rdy) begin errors++; $display("FAIL bp_in_ready_low got=1 exp=0"); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        checks++; if (out !== 16'h03A8) begin errors++; $display("FAIL bp_out_kept got=%h exp=03a8", out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_reset_mid_calc();
        logic [15:0] r; int l; logic seen;
        a = 8'h0F; b = 8'h0F; a_signed = 1'b0; b_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen) begin errors++; $display("FAIL midrst_no_valid got=pulse exp=none"); end
        do_op8(8'hFD, 8'h05, 1'b1, 1'b1, r, l);
        checks++; if (r !== 16'hFFF1) begin errors++; $display("FAIL midrst_next_op got=%h exp=fff1", r); end
    endtask

    task automatic test_early_term();
        logic [15:0] r; int l;
        do_op8(8'h07, 8'h01, 1'b0, 1'b0, r, l);
        checks++; if (r !== 16'h0007) begin errors++; $display("FAIL et_b01 got=%h exp=0007", r); end
        checks++; if (l !== LAT_B01) begin errors++; $display("FAIL et_b01_latency got=%0d exp=%0d", l, LAT_B01); end
        do_op8(8'h07, 8'h40, 1'b0, 1'b0, r, l);
        checks++; if (r !== 16'h01C0) begin errors++; $display("FAIL et_b40 got=%h exp=01c0", r); end
        checks++; if (l !== 4) begin errors++; $display("FAIL et_b40_latency got=%0d exp=4", l); end
        do_op8(8'h07, 8'hFF, 1'b1, 1'b1, r, l);
        checks++; if (r !== 16'hFFF9) begin errors++; $display("FAIL et_neg_b got=%h exp=fff9", r); end
        checks++; if (l !== 4) begin errors++; $display("FAIL et_neg_b_latency got=%0d exp=4", l); end
    endtask

    task automatic test_back_to_back();
        int first, second;
        first = -1; second = -1;
        a = 8'h03; b = 8'h05; a_signed = 1'b0; b_signed = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (in_ready) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (second - first !== 6) begin errors++; $display("FAIL b2b_interval got=%0d exp=6", second - first); end
        checks++; if (out !== 16'h000F) begin errors++; $display("FAIL b2b_result got=%h exp=000f", out); end
    endtask

    task automatic test_exhaustive_w4();
        int t, av, bv, prod;
        logic done;
        logic [7:0] got, exp;
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 256; i++) begin
                a4 = i[3:0]; b4 = i[7:4]; a_signed4 = m[0]; b_signed4 = m[1];
                av = a_signed4 ? int'($signed(a4)) : int'(a4);
                bv = b_signed4 ? int'($signed(b4)) : int'(b4);
                prod = av * bv;
                exp = prod[7:0];
                t = 0;
                while (!in_ready4 && t < 20) begin @(posedge clk); #1; t++; end
                in_valid4 = 1'b1;
                @(posedge clk); #1;
                in_valid4 = 1'b0;
                done = 1'b0; got = 'x;
                for (int c = 0; c < 60; c++) begin
                    out_ready4 = 1'($urandom_range(0, 1));
                    if (out_valid4 && out_ready4) begin got = out4; done = 1'b1; end
                    @(posedge clk); #1;
                    if (done) break;
                end
                out_ready4 = 1'b0;
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL w4 mode=%0d a=%h b=%h got=%h exp=%h", m, a4, b4, got, exp);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; a_signed4 = 1'b0; b_signed4 = 1'b0; out_ready4 = 1'b0;
        test_reset();
        test_signed_extremes();
        test_sign_modes();
        test_backpressure();
        test_reset_mid_calc();
        test_early_term();
        test_back_to_back();
        test_exhaustive_w4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
